// File: rtl/alu_collect_pkg.sv
// -----------------------------------------------------------------------------
// alu_collect_pkg
// Shared definitions for the ALU result collector:
//   - unit code constants (arith/logic/cmp/shift)
//   - layout of the per-entry header (optional tag, unit code, carry)
//   - HDR_W: header width (3, or 7 when ALU_COLLECT_TAG_EN is defined)
// A stored FIFO entry is {entry_hdr_t, data[WIDTH-1:0]}, i.e. WIDTH+HDR_W bits.
// Optional feature macro: ALU_COLLECT_TAG_EN (adds a 4-bit sequence tag).
// -----------------------------------------------------------------------------
package alu_collect_pkg;

    localparam int UNIT_W = 2;
    localparam int TAG_W  = 4;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef struct packed {
`ifdef ALU_COLLECT_TAG_EN
        logic [TAG_W-1:0]  tag;
`endif
        logic [UNIT_W-1:0] unit;
        logic              carry;
    } entry_hdr_t;

    localparam int HDR_W = $bits(entry_hdr_t);

    // Full entry width for a given data width.
    function automatic int entry_w(input int width);
        return width + HDR_W;
    endfunction

endpackage

// File: rtl/alu_collect_fifo.sv
// -----------------------------------------------------------------------------
// alu_collect_fifo
// Show-ahead FIFO: the head entry is visible on rd_data whenever the FIFO is
// non-empty, and rd_data reads 0 when empty.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wr_data   write request and entry (ignored when full without pop)
//   pop             remove head entry (ignored when empty)
//   rd_data         head entry, 0 when empty
//   full, empty     occupancy status
//   count           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_collect_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty   = (count_q == {CNT_W{1'b0}});
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? {W{1'b0}} : mem_q[rd_ptr_q];

    // Qualify requests: a push into a full FIFO only lands if a pop frees a slot.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all stored entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
// Collects the four ALU unit results, tags the single active one with its unit
// code, buffers it in a show-ahead FIFO and presents it over valid/ready.
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   *_OUT/*_Out, *_Flag         unit results and their valid flags
//   Carry_OUT                   arithmetic carry (stored for arith entries only)
//   Res_Ready                   consumer accepts head entry
//   Clr_Err                     clears sticky error bits (new errors win)
//   Res_Valid/Data/Carry/Unit   head entry, all 0 when empty
//   Res_Tag                     head sequence tag (only with ALU_COLLECT_TAG_EN)
//   Fifo_Count                  occupancy
//   Overflow, Multi_Flag_Err    sticky error flags
// Optional feature macro: ALU_COLLECT_TAG_EN.
// -----------------------------------------------------------------------------
module alu_result_collector
    import alu_collect_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [WIDTH-1:0]       Arith_OUT,
    input  logic                   Carry_OUT,
    input  logic                   Arith_Flag,
    input  logic [WIDTH-1:0]       Logic_Out,
    input  logic                   Logic_Flag,
    input  logic [WIDTH-1:0]       CMP_OUT,
    input  logic                   CMP_Flag,
    input  logic [WIDTH-1:0]       Shift_OUT,
    input  logic                   Shift_Flag,
    input  logic                   Res_Ready,
    input  logic                   Clr_Err,
    output logic                   Res_Valid,
    output logic [WIDTH-1:0]       Res_Data,
    output logic                   Res_Carry,
    output logic [1:0]             Res_Unit,
`ifdef ALU_COLLECT_TAG_EN
    output logic [3:0]             Res_Tag,
`endif
    output logic [$clog2(DEPTH):0] Fifo_Count,
    output logic                   Overflow,
    output logic                   Multi_Flag_Err
);

    localparam int ENTRY_W = entry_w(WIDTH);

    logic               push_req_s;
    logic               multi_s;
    logic [1:0]         unit_s;
    logic [WIDTH-1:0]   data_s;
    logic               carry_s;
    logic               pop_s;
    logic               push_acc_s;
    logic               full_s;
    logic               empty_s;
    entry_hdr_t         wr_hdr_s;
    entry_hdr_t         head_hdr_s;
    logic [ENTRY_W-1:0] head_s;
    logic               overflow_q, overflow_d;
    logic               multi_err_q, multi_err_d;

    // Select the single active unit; any multi-flag pattern is an error, no push.
    always_comb begin
        push_req_s = 1'b0;
        multi_s    = 1'b0;
        unit_s     = UNIT_ARITH;
        data_s     = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        case ({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag})
            4'b0000: push_req_s = 1'b0;
            4'b1000: begin
                push_req_s = 1'b1;
                unit_s     = UNIT_ARITH;
                data_s     = Arith_OUT;
                carry_s    = Carry_OUT;
            end
            4'b0100: begin
                push_req_s = 1'b1;
                unit_s     = UNIT_LOGIC;
                data_s     = Logic_Out;
            end
            4'b0010: begin
                push_req_s = 1'b1;
                unit_s     = UNIT_CMP;
                data_s     = CMP_OUT;
            end
            4'b0001: begin
                push_req_s = 1'b1;
                unit_s     = UNIT_SHIFT;
                data_s     = Shift_OUT;
            end
            default: multi_s = 1'b1;
        endcase
    end

    assign pop_s      = ~empty_s & Res_Ready;
    assign push_acc_s = push_req_s & (~full_s | pop_s);

`ifdef ALU_COLLECT_TAG_EN
    logic [3:0] tag_cnt_q, tag_cnt_d;

    // Tag counter advances only on pushes that actually enter the FIFO.
    always_comb begin
        if (push_acc_s) begin
            tag_cnt_d = tag_cnt_q + 4'd1;
        end else begin
            tag_cnt_d = tag_cnt_q;
        end
    end

    // Tag counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tag_cnt_q <= 4'd0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
        end
    end

    assign wr_hdr_s.tag = tag_cnt_q;
    assign Res_Tag      = head_hdr_s.tag;
`endif

    assign wr_hdr_s.unit  = unit_s;
    assign wr_hdr_s.carry = carry_s;

    alu_collect_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .push    (push_acc_s),
        .pop     (pop_s),
        .wr_data ({wr_hdr_s, data_s}),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (Fifo_Count)
    );

    // FIFO read data is already zero when empty, so the head fields follow.
    assign head_hdr_s = head_s[ENTRY_W-1:WIDTH];
    assign Res_Valid  = ~empty_s;
    assign Res_Data   = head_s[WIDTH-1:0];
    assign Res_Carry  = head_hdr_s.carry;
    assign Res_Unit   = head_hdr_s.unit;

    // Sticky error next-state: a new error in the clear cycle stays set.
    always_comb begin
        overflow_d  = (push_req_s & full_s & ~pop_s) | (overflow_q & ~Clr_Err);
        multi_err_d = multi_s | (multi_err_q & ~Clr_Err);
    end

    // Sticky error registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign Overflow       = overflow_q;
    assign Multi_Flag_Err = multi_err_q;

endmodule
